// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with per-way saturating direction counters,
// true-LRU replacement and registered mispredict redirect. `define BTB_STATS_EN adds statistics counters.
module btb_assoc #(
  parameter int SETS       = 512,
  parameter int WAYS       = 2,
  parameter int CTR_BITS   = 2,
  parameter int PC_W       = 32,
  parameter int PRED_DELAY = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic [PC_W-1:0] Instr_PC_IN_IF,
  input  logic [PC_W-1:0] Instr_PC_IN_ID,
  input  logic            is_Branch_IN_ID,
  input  logic            is_Taken_IN_ID,
  input  logic [PC_W-1:0] Alt_PC_IN_ID,
  output logic            FLUSH,
  output logic            take_Branch_OUT_IF,
  output logic [PC_W-1:0] take_Alt_PC_OUT_IF
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups_OUT,
  output logic [31:0]     stat_hits_OUT,
  output logic [31:0]     stat_branches_OUT,
  output logic [31:0]     stat_mispred_OUT
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  localparam int TGT_W = PC_W - 2;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                valid_q  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
  logic [TGT_W-1:0]    target_q [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
  logic [AGE_W-1:0]    age_q    [SETS][WAYS];

  logic            rec_taken_q  [PRED_DELAY];
  logic [PC_W-1:0] rec_target_q [PRED_DELAY];

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  assign if_idx = Instr_PC_IN_IF[1+IDX_W:2];
  assign if_tag = Instr_PC_IN_IF[PC_W-1:2+IDX_W];
  assign id_idx = Instr_PC_IN_ID[1+IDX_W:2];
  assign id_tag = Instr_PC_IN_ID[PC_W-1:2+IDX_W];

  logic             if_hit, id_hit, found_inv, acc_valid;
  logic [AGE_W-1:0] if_way, id_way, victim, acc_way, acc_age;
  logic [WAYS-1:0]  bump;

  always_comb begin
    if_hit = 1'b0;
    if_way = '0;
    id_hit = 1'b0;
    id_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[if_idx][w] && tag_q[if_idx][w] == if_tag) begin
        if_hit = 1'b1;
        if_way = AGE_W'(w);
      end
      if (valid_q[id_idx][w] && tag_q[id_idx][w] == id_tag) begin
        id_hit = 1'b1;
        id_way = AGE_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the way holding the maximum age (WAYS-1).
  always_comb begin
    found_inv = 1'b0;
    victim    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[id_idx][w] && !found_inv) begin
        found_inv = 1'b1;
        victim    = AGE_W'(w);
      end
    end
    if (!found_inv) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[id_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
      end
    end
  end

  // Filling an invalid way counts as coming from "older than everything": all valid ways age.
  always_comb begin
    bump      = '0;
    acc_way   = id_hit ? id_way : victim;
    acc_valid = valid_q[id_idx][acc_way];
    acc_age   = age_q[id_idx][acc_way];
    for (int unsigned w = 0; w < WAYS; w++) begin
      bump[w] = valid_q[id_idx][w] && (AGE_W'(w) != acc_way) &&
                (!acc_valid || age_q[id_idx][w] < acc_age);
    end
  end

  logic [CTR_BITS-1:0] ctr_next;
  always_comb begin
    ctr_next = ctr_q[id_idx][id_way];
    if (is_Taken_IN_ID) begin
      if (ctr_next != '1) ctr_next = ctr_next + CTR_BITS'(1);
    end else if (ctr_next != '0) begin
      ctr_next = ctr_next - CTR_BITS'(1);
    end
  end

  logic            pred_taken, mispred, next_taken, do_update;
  logic [PC_W-1:0] pred_target, correct_pc, next_target;
  logic            rec_taken;
  logic [PC_W-1:0] rec_target;

  assign pred_taken  = if_hit && ctr_q[if_idx][if_way][CTR_BITS-1];
  assign pred_target = pred_taken ? {target_q[if_idx][if_way], 2'b00}
                                  : Instr_PC_IN_IF + PC_W'(4);
  assign rec_taken   = rec_taken_q[PRED_DELAY-1];
  assign rec_target  = rec_target_q[PRED_DELAY-1];
  assign mispred     = is_Branch_IN_ID &&
                       ((rec_taken != is_Taken_IN_ID) ||
                        (rec_taken && is_Taken_IN_ID && rec_target != Alt_PC_IN_ID));
  assign correct_pc  = is_Taken_IN_ID ? Alt_PC_IN_ID : Instr_PC_IN_ID + PC_W'(8);
  assign next_taken  = mispred ? 1'b1 : pred_taken;
  assign next_target = mispred ? correct_pc : pred_target;
  assign do_update   = !STALL && is_Branch_IN_ID && (id_hit || is_Taken_IN_ID);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FLUSH              <= 1'b0;
      take_Branch_OUT_IF <= 1'b0;
      take_Alt_PC_OUT_IF <= '0;
      for (int unsigned i = 0; i < PRED_DELAY; i++) begin
        rec_taken_q[i]  <= 1'b0;
        rec_target_q[i] <= '0;
      end
    end else if (!STALL) begin
      FLUSH              <= mispred;
      take_Branch_OUT_IF <= next_taken;
      take_Alt_PC_OUT_IF <= next_target;
      rec_taken_q[0]     <= next_taken;
      rec_target_q[0]    <= next_target;
      for (int unsigned i = 1; i < PRED_DELAY; i++) begin
        rec_taken_q[i]  <= rec_taken_q[i-1];
        rec_target_q[i] <= rec_target_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[i][w] <= 1'b0;
          ctr_q[i][w]   <= '0;
          age_q[i][w]   <= '0;
        end
      end
    end else if (do_update) begin
      valid_q[id_idx][acc_way] <= 1'b1;
      ctr_q[id_idx][acc_way]   <= id_hit ? ctr_next : CTR_BITS'(1) << (CTR_BITS - 1);
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (bump[w]) age_q[id_idx][w] <= age_q[id_idx][w] + AGE_W'(1);
      end
      age_q[id_idx][acc_way] <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && do_update) begin
      tag_q[id_idx][acc_way] <= id_tag;
      if (is_Taken_IN_ID) target_q[id_idx][acc_way] <= Alt_PC_IN_ID[PC_W-1:2];
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_lookups_OUT  <= '0;
      stat_hits_OUT     <= '0;
      stat_branches_OUT <= '0;
      stat_mispred_OUT  <= '0;
    end else if (!STALL) begin
      stat_lookups_OUT <= stat_lookups_OUT + 32'd1;
      if (if_hit)          stat_hits_OUT     <= stat_hits_OUT + 32'd1;
      if (is_Branch_IN_ID) stat_branches_OUT <= stat_branches_OUT + 32'd1;
      if (mispred)         stat_mispred_OUT  <= stat_mispred_OUT + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_btb_assoc;
  localparam int SETS       = 512;
  localparam int WAYS       = 2;
  localparam int PRED_DELAY = 1;
  localparam int CTR_MAX    = 3;
  localparam int CTR_WEAK   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br, tk;
  logic [31:0] if_pc, id_pc, alt;
  logic        flush, take;
  logic [31:0] alt_out;

  btb_assoc #(
    .SETS(SETS), .WAYS(WAYS), .CTR_BITS(2), .PC_W(32), .PRED_DELAY(PRED_DELAY)
  ) dut (
    .CLK(clk), .RESET(rst), .STALL(stall),
    .Instr_PC_IN_IF(if_pc), .Instr_PC_IN_ID(id_pc),
    .is_Branch_IN_ID(br), .is_Taken_IN_ID(tk), .Alt_PC_IN_ID(alt),
    .FLUSH(flush), .take_Branch_OUT_IF(take), .take_Alt_PC_OUT_IF(alt_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: per-set entries with a last-use timestamp (LRU = oldest stamp).
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_tag   [SETS][WAYS];
  logic [31:0] m_tgt   [SETS][WAYS];
  int          m_ctr   [SETS][WAYS];
  longint      m_stamp [SETS][WAYS];
  longint      now = 0;
  logic [32:0] rec_q[$];
  bit          e_flush, e_take;
  logic [31:0] e_alt;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int find_way(input logic [31:0] pc);
    int s = set_of(pc);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == (pc >> 11)) return w;
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit s, input logic [31:0] ipc, input logic [31:0] dpc,
                            input bit b, input bit t, input logic [31:0] a);
    int hw, dw, sd, vic;
    bit p_tk, mis;
    logic [31:0] p_tgt;
    logic [32:0] rec;
    longint best;
    if (r) begin
      foreach (m_valid[i, j]) begin
        m_valid[i][j] = 0;
        m_ctr[i][j]   = 0;
        m_stamp[i][j] = 0;
      end
      rec_q.delete();
      repeat (PRED_DELAY) rec_q.push_back('0);
      e_flush = 0; e_take = 0; e_alt = '0;
      return;
    end
    if (s) return;
    hw    = find_way(ipc);
    p_tk  = (hw >= 0) && (m_ctr[set_of(ipc)][hw] >= CTR_WEAK);
    p_tgt = p_tk ? m_tgt[set_of(ipc)][hw] : ipc + 32'd4;
    rec   = rec_q.pop_front();
    mis   = b && ((rec[32] != t) || (t && rec[31:0] != a));
    e_flush = mis;
    e_take  = mis ? 1'b1 : p_tk;
    e_alt   = mis ? (t ? a : dpc + 32'd8) : p_tgt;
    rec_q.push_back({e_take, e_alt});
    if (!b) return;
    sd = set_of(dpc);
    dw = find_way(dpc);
    if (dw >= 0) begin
      m_ctr[sd][dw] = t ? ((m_ctr[sd][dw] < CTR_MAX) ? m_ctr[sd][dw] + 1 : CTR_MAX)
                        : ((m_ctr[sd][dw] > 0) ? m_ctr[sd][dw] - 1 : 0);
      if (t) m_tgt[sd][dw] = a & ~32'd3;
      now++;
      m_stamp[sd][dw] = now;
    end else if (t) begin
      vic = -1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[sd][w] && vic < 0) vic = w;
      if (vic < 0) begin
        best = 64'h7fff_ffff_ffff_ffff;
        for (int w = 0; w < WAYS; w++)
          if (m_stamp[sd][w] < best) begin best = m_stamp[sd][w]; vic = w; end
      end
      m_valid[sd][vic] = 1;
      m_tag[sd][vic]   = dpc >> 11;
      m_tgt[sd][vic]   = a & ~32'd3;
      m_ctr[sd][vic]   = CTR_WEAK;
      now++;
      m_stamp[sd][vic] = now;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit s, input logic [31:0] ipc,
                      input logic [31:0] dpc, input bit b, input bit t, input logic [31:0] a);
    rst = r; stall = s; if_pc = ipc; id_pc = dpc; br = b; tk = t; alt = a;
    model_step(r, s, ipc, dpc, b, t, a);
    @(posedge clk);
    #1;
    check_val({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check_val({tag, ".take"},  32'(take),  32'(e_take));
    check_val({tag, ".alt"},   alt_out,    e_alt);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    logic [31:0] prev_if, ipc, a;
    bit r, s, b, t;
    rst = 1'b1; stall = 1'b1; br = 1'b0; tk = 1'b0;
    if_pc = '0; id_pc = '0; alt = '0;

    step("reset", 1, 1, 32'h0, 32'h0, 0, 0, 32'h0);
    check_val("reset_take", 32'(take), 32'd0);
    check_val("reset_alt", alt_out, 32'd0);
    step("lookup400", 0, 0, 32'h400, 32'h0, 0, 0, 32'h0);
    check_val("lookup400_alt", alt_out, 32'h404);

    step("cold", 0, 0, 32'h1004, 32'h1000, 1, 1, 32'h2000);
    check_val("cold_flush", 32'(flush), 32'd1);
    check_val("cold_alt", alt_out, 32'h2000);
    step("cold_if", 0, 0, 32'h1000, 32'h1004, 0, 0, 32'h0);
    check_val("cold_if_take", 32'(take), 32'd1);
    check_val("cold_if_alt", alt_out, 32'h2000);

    step("hyst", 0, 0, 32'h1004, 32'h1000, 1, 0, 32'h0);
    check_val("hyst_alt", alt_out, 32'h1008);
    step("hyst_if", 0, 0, 32'h1000, 32'h1004, 0, 0, 32'h0);
    check_val("hyst_if_take", 32'(take), 32'd0);
    check_val("hyst_if_alt", alt_out, 32'h1004);

    step("retrain", 0, 0, 32'h1004, 32'h1000, 1, 1, 32'h2000);
    step("wt_pre", 0, 0, 32'h1000, 32'h1004, 0, 0, 32'h0);
    step("wrongtgt", 0, 0, 32'h1004, 32'h1000, 1, 1, 32'h3000);
    check_val("wrongtgt_flush", 32'(flush), 32'd1);
    check_val("wrongtgt_alt", alt_out, 32'h3000);
    step("wt_if", 0, 0, 32'h1000, 32'h1004, 0, 0, 32'h0);
    check_val("wt_if_alt", alt_out, 32'h3000);

    step("lru_a", 0, 0, 32'h1804, 32'h1800, 1, 1, 32'h2800);
    step("lru_b", 0, 0, 32'h2004, 32'h2000, 1, 1, 32'h4000);
    step("lru_if1000", 0, 0, 32'h1000, 32'h2004, 0, 0, 32'h0);
    check_val("lru_evicted_take", 32'(take), 32'd0);
    step("lru_if1800", 0, 0, 32'h1800, 32'h1000, 0, 0, 32'h0);
    check_val("lru_kept_alt", alt_out, 32'h2800);

    step("rbw", 0, 0, 32'h3000, 32'h3000, 1, 1, 32'h2800);
    check_val("rbw_flush", 32'(flush), 32'd0);
    check_val("rbw_old_alt", alt_out, 32'h3004);
    step("rbw_new", 0, 0, 32'h3000, 32'h3004, 0, 0, 32'h0);
    check_val("rbw_new_alt", alt_out, 32'h2800);

    step("stall", 0, 1, 32'h1000, 32'h3000, 1, 1, 32'h6000);
    check_val("stall_flush", 32'(flush), 32'd0);
    check_val("stall_hold_alt", alt_out, 32'h2800);
    step("unstall", 0, 0, 32'h1000, 32'h3000, 1, 0, 32'h0);
    check_val("unstall_alt", alt_out, 32'h3008);
    step("unstall_if", 0, 0, 32'h3000, 32'h1000, 0, 0, 32'h0);
    check_val("unstall_if_alt", alt_out, 32'h3004);

    prev_if = 32'h3000;
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 9) == 0);
      ipc = rand_pc();
      b   = 1'($urandom_range(0, 1));
      t   = ($urandom_range(0, 3) != 0);
      a   = 32'h8000 | (32'($urandom_range(0, 3)) << 4);
      step("rnd", r, s, ipc, prev_if, b, t, a);
      if (r || !s) prev_if = ipc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer with per-entry saturating direction counters and true-LRU replacement. It sits between the IF and ID stages of the pipeline. Each cycle it looks up the fetch PC and registers a taken/target prediction for IF. It also resolves the branch currently in ID against the prediction made for it, and on a mispredict it raises a one-cycle FLUSH and a corrected redirect. Unlike the fixed 512x2 BTB with a single shared prediction bit, the geometry and counter width are configurable, each way carries its own counter, and not-taken branches that miss are never allocated.

## Interface
- SETS, 512, number of sets; power of 2, ≥2; IDX_W = log2(SETS)
- WAYS, 2, associativity; one of 1, 2, 4
- CTR_BITS, 2, direction counter width; ≥1
- PC_W, 32, PC width; tag = PC[PC_W-1:2+IDX_W], index = PC[1+IDX_W:2], stored target = PC[PC_W-1:2]
- PRED_DELAY, 1, non-stalled cycles between a PC in IF and the same PC in ID; ≥1
- CLK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high; priority over STALL
- STALL  in  1  freezes all state and outputs
- Instr_PC_IN_IF  in  PC_W  fetch PC to look up
- Instr_PC_IN_ID  in  PC_W  PC of instruction in decode
- is_Branch_IN_ID  in  1  ID instruction is a conditional branch
- is_Taken_IN_ID  in  1  resolved direction
- Alt_PC_IN_ID  in  PC_W  resolved taken target
- FLUSH  out  1  mispredict; squash younger instructions
- take_Branch_OUT_IF  out  1  redirect fetch
- take_Alt_PC_OUT_IF  out  PC_W  next fetch PC
- stat_lookups_OUT / stat_hits_OUT / stat_branches_OUT / stat_mispred_OUT  out  32 each  (only with BTB_STATS_EN)

## Operation
- **Entry contents:** valid, tag, target[PC_W-3:0], counter[CTR_BITS-1:0], age[log2 WAYS]. Age is absent when WAYS=1.
- **Lookup (IF, combinational read):** hit = any way in the set with valid and matching tag. There is at most one hit way.
  - pred_taken = hit && counter MSB.
  - pred_target = pred_taken ? {target,2'b00} : Instr_PC_IN_IF+4.
- **Prediction record:** a delay line of PRED_DELAY entries of {taken, target}. It advances on every non-stalled cycle. The oldest entry is the prediction for the instruction now in ID.
- **Mispredict:** occurs when is_Branch_IN_ID and either:
  - rec.taken ≠ is_Taken_IN_ID, or
  - both are taken and rec.target ≠ Alt_PC_IN_ID.
- **Correct PC:**
  - is_Taken_IN_ID → Alt_PC_IN_ID.
  - not taken → Instr_PC_IN_ID+8 (skips the delay slot).
- **Next-cycle outputs:**
  - On mispredict: FLUSH=1, take_Branch_OUT_IF=1, take_Alt_PC_OUT_IF=correct PC. The record pushed is {1, correct PC}.
  - Otherwise: FLUSH=0, take_Branch_OUT_IF=pred_taken, take_Alt_PC_OUT_IF=pred_target. The record pushed is {pred_taken, pred_target}.
- **Update (ID, non-stalled, is_Branch_IN_ID):**
  - Hit, any direction: the counter saturates up if taken, down if not. Target is written with Alt_PC[PC_W-1:2] only if taken. The hit way becomes MRU.
  - Miss and taken: allocate the lowest-index invalid way. If every way is valid, replace the way with the maximum age. Write valid=1, tag, target, counter=2^(CTR_BITS-1) (weakly taken). The new way becomes MRU.
  - Miss and not taken: no table change.
- **LRU:** the accessed way gets age 0. Ways whose age is less than the accessed way's old age increment by 1. Ages stay a permutation of 0..WAYS-1.
- **Same-set conflict:** when IF and ID address the same set in one cycle, the IF lookup sees pre-update contents (read-before-write).

## Timing
- **Reset:** outputs are 0 on the cycle after RESET is sampled high. All valid bits, ages, counters and delay-line entries are cleared to 0. The table is fully cleared in one cycle. RESET asserted mid-mispredict cancels the pending FLUSH.
- **Prediction latency:** 1 cycle, from Instr_PC_IN_IF sampled to registered outputs.
- **Mispredict response:** FLUSH is asserted the cycle after the resolving edge, for exactly one cycle unless the next ID is also a mispredict. It overrides that cycle's IF prediction.
- **Update visibility:** a table write at edge N is visible to the IF lookup evaluated after edge N.
- **STALL:** outputs, table, delay line and statistics hold. is_Branch_IN_ID is ignored while stalled.

## Configuration
- **BTB_STATS_EN defined:** four 32-bit wrapping counters, cleared by RESET and held during STALL. Each increments on a non-stalled cycle as follows:
  - lookups: every such cycle.
  - hits: every IF hit.
  - branches: every cycle with is_Branch_IN_ID high.
  - mispred: every mispredict.
- **BTB_STATS_EN undefined:** the counters and their ports are absent. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- **Reset:** hold RESET 1 cycle with STALL=1. Then take_Branch_OUT_IF=0, take_Alt_PC_OUT_IF=0, FLUSH=0. Next lookup of 0x400 predicts 0x404.
- **Cold taken miss:** branch at 0x1000 taken to 0x2000, recorded prediction not-taken. Next cycle: FLUSH=1, take_Alt_PC_OUT_IF=0x2000. The entry is allocated weakly taken. A later IF at 0x1000 predicts take=1, target 0x2000.
- **Counter hysteresis:** after the allocation above, resolve 0x1000 not-taken once. Result: FLUSH=1, redirect 0x1008, counter=01. The next IF at 0x1000 predicts not-taken (0x1004).
- **LRU replacement:** taken branches at 0x1000, 0x1800 and 0x2000 (same set 0, distinct tags), in that order. The third evicts 0x1000: an IF at 0x1000 misses, and 0x1800 still hits.
- **Wrong target:** hit predicting 0x2000 but resolved taken to 0x3000 → FLUSH=1, redirect 0x3000, stored target becomes 0x3000.
- **STALL and same-set conflict:**
  - With STALL=1 during a mispredicting ID branch: no FLUSH and no table change until STALL drops.
  - An IF read and ID write to the same set in one cycle return the old entry.
